// File: rtl/bcd_counter_9999_pkg.sv
// bcd_counter_9999_pkg: shared types, glyphs and BCD step helper for the 4-digit counter/display
package bcd_disp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_RESET = 4'b1110;
  // returns {wrap, next}: ripples a +/-1 step through four BCD digits
  function automatic logic [16:0] bcd_step(input logic [15:0] d, input logic up);
    logic [15:0] r;
    logic p;
    r = d;
    p = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (p) begin
        p = up ? d[i*4 +: 4] >= 4'd9 : d[i*4 +: 4] == 4'd0;
        r[i*4 +: 4] = up ? (p ? 4'd0 : d[i*4 +: 4] + 4'd1) : (p ? 4'd9 : d[i*4 +: 4] - 4'd1);
      end
    end
    return {p, r};
  endfunction
endpackage

// File: rtl/bcd_counter_9999_if.sv
// bcd_counter_9999_if: control strobes in, count and display pins out
interface bcd_counter_9999_if;
  logic itick;
  logic iup;
  logic istartstop;
  logic iclear;
  logic [15:0] oDigits;
  logic oCarry;
  logic oRunning;
  logic [3:0] oAnodes;
  logic [6:0] oSegments;
  modport master (output itick, iup, istartstop, iclear, input oDigits, oCarry, oRunning, oAnodes, oSegments);
  modport slave (input itick, iup, istartstop, iclear, output oDigits, oCarry, oRunning, oAnodes, oSegments);
endinterface

// File: rtl/bcd_counter_9999_seg7_decode.sv
// seg7_decode: BCD digit to active-low gfedcba segments, codes above 9 blank
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_counter_9999.sv
// bcd_counter_9999: run/hold/clear BCD counter 0000-9999 with multiplexed 7-seg display
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_counter_9999
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50_000,
  parameter int SCAN_W = 16
) (
  input logic iclk,
  input logic irst,
  bcd_counter_9999_if.slave bus
);
  state_e state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic carry_q, carry_d, running_q, running_d, count_en, wrap, blank;
  logic [16:0] step;
  logic [SCAN_W-1:0] presc_q, presc_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] anodes_q, anodes_d;
  logic [6:0] seg_q, seg_d, dec;
  always_ff @(posedge iclk) begin
    if (!irst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (bus.iclear) state_d = IDLE;
    else if (bus.istartstop) state_d = state_q == RUN ? HOLD : RUN;
  end
  always_comb begin
    count_en = state_q == RUN && bus.itick && !bus.iclear;
    step = bcd_step(digits_q, bus.iup);
    digits_d = bus.iclear ? 16'h0000 : count_en ? step[15:0] : digits_q;
    carry_d = count_en && step[16];
    running_d = state_d == RUN;
  end
  // the display decodes the registered count, so it trails the count by one cycle
  always_comb begin
    wrap = presc_q == SCAN_W'(SCAN_DIV - 1);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    anodes_d = ~(4'b0001 << idx_d);
    seg_d = blank ? SEG_BLANK : dec;
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = |idx_d && (digits_q >> {idx_d, 2'b00}) == 16'h0000;
`else
  assign blank = 1'b0;
`endif
  seg7_decode u_dec (.bcd_i(digits_q[idx_d*4 +: 4]), .seg_o(dec));
  always_ff @(posedge iclk) begin
    if (!irst) begin
      digits_q <= 16'h0000;
      carry_q <= 1'b0;
      running_q <= 1'b0;
      presc_q <= '0;
      idx_q <= 2'd0;
      anodes_q <= ANODE_RESET;
      seg_q <= SEG_0;
    end else begin
      digits_q <= digits_d;
      carry_q <= carry_d;
      running_q <= running_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      anodes_q <= anodes_d;
      seg_q <= seg_d;
    end
  end
  assign bus.oDigits = digits_q;
  assign bus.oCarry = carry_q;
  assign bus.oRunning = running_q;
  assign bus.oAnodes = anodes_q;
  assign bus.oSegments = seg_q;
endmodule

// File: tb/tb_bcd_counter_9999.sv
// tb_bcd_counter_9999: directed run/hold/clear/wrap/scan checks against a decimal reference model
module tb_bcd_counter_9999;
  localparam int SD = 4;
  typedef struct {
    logic [15:0] d;
    logic c;
    logic r;
    logic [3:0] an;
    logic [6:0] sg;
  } exp_t;
  logic iclk = 1'b0;
  logic irst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cnt = 0;
  int st = 0;
  int pre = 0;
  int idx = 0;
  logic car = 1'b0;
  exp_t q[$];
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  bcd_counter_9999_if bus ();
  bcd_counter_9999 #(.SCAN_DIV(SD), .SCAN_W(16)) dut (.iclk(iclk), .irst(irst), .bus(bus));
  always #5 iclk = ~iclk;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [6:0] show(input int v, input int k);
    int p;
    p = k == 0 ? 1 : k == 1 ? 10 : k == 2 ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && v < p) return 7'h7f;
`endif
    return glyph[(v / p) % 10];
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // st: 0 IDLE, 1 RUN, 2 HOLD
  task automatic cyc(input logic t, input logic u, input logic ss, input logic clr, input logic rn = 1'b1);
    int old;
    exp_t e;
    bus.itick = t;
    bus.iup = u;
    bus.istartstop = ss;
    bus.iclear = clr;
    irst = rn;
    old = cnt;
    car = 1'b0;
    if (!rn) begin
      st = 0; cnt = 0; pre = 0; idx = 0;
    end else begin
      if (clr) begin
        st = 0; cnt = 0;
      end else begin
        if (st == 1 && t) begin
          if (u) begin car = cnt == 9999; cnt = (cnt + 1) % 10000; end
          else begin car = cnt == 0; cnt = (cnt + 9999) % 10000; end
        end
        if (ss) st = st == 1 ? 2 : 1;
      end
      if (pre == SD - 1) begin pre = 0; idx = (idx + 1) % 4; end
      else pre++;
    end
    e.d = to_bcd(cnt);
    e.c = car;
    e.r = st == 1;
    e.an = ~(4'b0001 << idx);
    e.sg = rn ? show(old, idx) : 7'h40;
    q.push_back(e);
    @(posedge iclk);
    #1;
    e = q.pop_front();
    chk("digits", bus.oDigits, e.d);
    chk("carry", 16'(bus.oCarry), 16'(e.c));
    chk("running", 16'(bus.oRunning), 16'(e.r));
    chk("anodes", 16'(bus.oAnodes), 16'(e.an));
    chk("segments", 16'(bus.oSegments), 16'(e.sg));
    bus.itick = 1'b0;
    bus.istartstop = 1'b0;
    bus.iclear = 1'b0;
    irst = 1'b1;
  endtask
  task automatic ticks(input int n, input logic u);
    for (int i = 0; i < n; i++) cyc(1'b1, u, 1'b0, 1'b0);
  endtask
  initial begin
    bus.itick = 1'b0;
    bus.iup = 1'b1;
    bus.istartstop = 1'b0;
    bus.iclear = 1'b0;
    cyc(0, 1, 0, 0, 1'b0);
    cyc(0, 1, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); end
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); end
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0);
    ticks(2, 1'b0);
    ticks(2, 1'b1);
    cyc(0, 1, 0, 0);
    ticks(1, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0);
    ticks(123, 1'b1);
    cyc(1, 1, 1, 0);
    ticks(5, 1'b1);
    cyc(1, 1, 1, 0);
    ticks(1, 1'b1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0);
    ticks(500, 1'b1);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    ticks(7, 1'b1);
    cyc(1, 1, 0, 0, 1'b0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    ticks(42, 1'b1);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 4 * SD + 3; i++) cyc(0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bcd_counter_9999.md
Name: bcd_counter_9999

Overview:
Consumer end of the 1 Hz tick-divider link. Takes the divider's single-cycle strobe and counts 0000–9999 in four BCD digits, with run/hold/clear control. Time-multiplexes the digits onto a common-anode 4-digit seven-segment display. Sits between the tick divider and the board display pins.

Parameters:
SCAN_DIV, 50_000, iclk cycles per display digit slot (1 kHz scan at 50 MHz); must be >= 2
SCAN_W, 16, width of the scan prescaler; must hold SCAN_DIV-1

Ports:
iclk  in  1  system clock
irst  in  1  synchronous reset, active-low
itick  in  1  count strobe from the divider, one iclk cycle wide
iup  in  1  1 = count up, 0 = count down; sampled with itick
istartstop  in  1  one-cycle pulse that toggles run/hold (debounced upstream)
iclear  in  1  one-cycle pulse that clears the count and returns to IDLE
oDigits  out  16  BCD count, [15:12] = thousands … [3:0] = units
oCarry  out  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down)
oRunning  out  1  1 while in RUN
oAnodes  out  4  digit enables, active-low, [0] = units
oSegments  out  7  segments gfedcba, active-low

Behaviour:
- Reset: irst is sampled on the rising edge of iclk; irst=0 at any edge is reset.
  - State goes to IDLE; oDigits=16'h0000; oCarry=0; oRunning=0.
  - Scan index=0, prescaler=0, oAnodes=4'b1110, oSegments=7'b1000000 (glyph "0").
  - Reset mid-count or mid-scan discards all state, with no residual carry.
- FSM states: IDLE, RUN, HOLD. Priority order is irst > iclear > istartstop.
  - IDLE: count held at 0000. istartstop -> RUN.
  - RUN: count on itick. istartstop -> HOLD.
  - HOLD: count frozen, itick ignored. istartstop -> RUN.
  - iclear in any state -> IDLE with oDigits=0 on the next edge. Any itick or istartstop in the same cycle is ignored.
- Counting: applies only when the current (pre-edge) state is RUN and itick=1.
  - A tick arriving in the same cycle as the istartstop that leaves RUN is counted.
  - A tick arriving in the same cycle as the HOLD->RUN transition is not counted.
- Latency: oDigits and oCarry update on the edge that samples itick, and are visible one cycle after the strobe.
- Arithmetic: each digit 0..9. The units digit steps ±1; a digit rolls 9->0 (up) or 0->9 (down) and propagates to the next digit.
  - 9999 up -> 0000 with oCarry=1 for exactly one cycle.
  - 0000 down -> 9999 with oCarry=1 for exactly one cycle.
  - No other transition asserts oCarry.
  - Digit values A–F are unreachable. If one is forced, the next count treats it as 9 (up) or 0 (down) semantics are not required; the decoder shows blank.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously in every state.
  - On the wrap to 0, the scan index advances 0->1->2->3->0.
  - oAnodes has exactly one low bit, equal to the index. oSegments shows the decoded digit[index].
  - Both outputs are registered and change together on the same edge.
  - The decoder uses the registered oDigits, so the display lags the count by at most one cycle.
- oRunning is registered as (state == RUN).

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: leading-zero digits are blanked.
  - While scanning digit k (k=3,2,1), if every digit at position >= k is 0, oSegments=7'b1111111 and oAnodes stays active.
  - The units digit is never blanked; 0042 displays as "  42".
- Undefined: all four digits always display; 0042 displays as "0042".
- Count, oDigits and oCarry are identical in both builds.

Decomposition:
- Package bcd_disp_pkg holds:
  - state enum (IDLE/RUN/HOLD);
  - the 7-bit active-low glyph constants SEG_0..SEG_9 and SEG_BLANK;
  - ANODE_RESET = 4'b1110.
- Sub-module seg7_decode: purely combinational. Takes 4-bit BCD in and gives 7-bit active-low segments out; codes >9 give SEG_BLANK.

Test Plan:
- Reset -> oDigits=0000, oAnodes=1110, oSegments=1000000, oRunning=0, oCarry=0.
- IDLE, 3 itick strobes -> oDigits stays 0000. Then istartstop plus 3 ticks -> 0003, with oDigits changing exactly 1 cycle after each tick.
- RUN at 9998, iup=1, 2 ticks -> 9999 then 0000 with oCarry high for one cycle. Then iup=0 with 1 tick -> 9999 with oCarry pulsing again.
- RUN at 0123: istartstop and itick in the same cycle -> 0124 and HOLD; 5 more ticks -> 0124. Then istartstop and itick together -> RUN, still 0124.
- iclear asserted together with istartstop and itick at 0500 -> 0000, IDLE, oRunning=0. Also irst=0 mid-count -> full reset values.
- SCAN_DIV=4, count 0042 -> oAnodes cycles 1110,1101,1011,0111 every 4 cycles. Segments show 2, 4, 0, 0, or 2, 4, blank, blank when LEADING_ZERO_BLANK_EN is defined.
